fp_addsub_seq: RTL and testbench
================================

Name: fp_addsub_seq

Overview:
- Multi-cycle IEEE-754 single-precision adder/subtractor with valid/ready handshakes on input and output.
- Computes a + b (op=0) or a - b (op=1) through an FSM that aligns and normalizes one bit per cycle.
- Sits in the RISC-V FP execute path as the general two-operand add/sub unit, beside the constant-operand subtract block.

Parameters:
- MAX_ALIGN_SHIFT, 27, cap on alignment shift count; larger exponent differences are clipped to this value.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands a, b and op are valid.
- in_ready  output  1  unit can accept operands; high only in IDLE.
- a  input  32  IEEE-754 single-precision operand A.
- b  input  32  IEEE-754 single-precision operand B.
- op  input  1  0 = add, 1 = subtract (sign of b inverted).
- out_valid  output  1  result is valid; held until accepted.
- out_ready  input  1  consumer accepts result.
- result  output  32  IEEE-754 single-precision result.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, reset=0): state IDLE, result=0, out_valid=0, busy=0, all datapath registers cleared. in_ready=1 once reset is released. Assertion at any point aborts the operation in flight, with no output.
- Acceptance: on edge E0 where in_valid && in_ready, capture operands.
  - Unpack each operand to sign, exponent, and 24-bit mantissa with hidden bit.
  - exp==0 means the operand is zero; denormals are flushed to zero.
  - Effective sign of b = b[31]^op.
- States: IDLE -> ALIGN -> ADD -> NORM -> PACK -> DONE -> IDLE.
- Datapath mantissa width: 24 bits plus guard/round/sticky = 27 bits, plus 1 carry bit.
- ALIGN:
  - Load count = min(|exp_a - exp_b|, MAX_ALIGN_SHIFT).
  - Each cycle with count != 0: shift the smaller-exponent mantissa right by 1, OR the shifted-out bit into sticky, and decrement count.
  - Go to ADD in the cycle count == 0. ALIGN therefore lasts count+1 cycles.
  - Result exponent = the larger exponent.
- ADD (1 cycle):
  - Same effective signs: add magnitudes, sign = sign_a.
  - Different signs: subtract the smaller magnitude from the larger; sign = sign of the larger.
  - Equal magnitudes give +0 (sign forced to 0).
- NORM:
  - First cycle, carry set: shift right 1, exp+1, go to PACK.
  - Otherwise, each cycle with mantissa nonzero, bit23 == 0 and exp > 1: shift left 1, exp-1.
  - Exit to PACK when bit23 == 1, mantissa == 0, or exp == 1. NORM lasts 1+s cycles, where s = number of left shifts.
- PACK (1 cycle): round (see Optional Feature), then pack the result.
  - Zero mantissa -> 0x00000000.
  - exp >= 255 -> {sign, 0xFF, 0}.
  - Bit23 still clear at exp == 1 -> flush to 0x00000000.
  - Otherwise -> {sign, exp, mant[22:0]}.
- Latency: out_valid rises after edge E0 + 4 + count + s.
- Special operands, detected at acceptance, go directly to PACK; out_valid rises after edge E0+1.
  - Either operand NaN, or inf minus inf -> 0x7FC00000.
  - inf combined with finite -> inf carrying the infinite operand's effective sign.
  - Both operands zero -> 0x00000000.
- DONE:
  - out_valid=1 and result is stable.
  - On out_ready=1: out_valid -> 0 and state -> IDLE at that edge. The next operand cannot be accepted in the same cycle.
  - out_ready=1 outside DONE is ignored.
  - in_valid while busy is ignored; the upstream holds its operands.

Optional Feature:
- Macro: FP_ROUND_NEAREST_EN.
- Defined: round-to-nearest-even in PACK using guard/round/sticky.
  - Increment the mantissa when G && (R || S || lsb).
  - Increment carry-out -> mantissa = 0x800000 and exp+1, re-checked for overflow to inf.
- Undefined: truncation (round toward zero); guard/round/sticky logic is absent.
- Latency is identical in both builds.

Test Plan:
- a=0x3F800000, b=0x3F800000, op=0 -> result 0x40000000; out_valid after E0+4.
- a=0x40000000, b=0x3F000000, op=1 (2.0-0.5): count=2, s=1 -> result 0x3FC00000; out_valid after E0+7.
- a=0x40400000, b=0x40400000, op=1 -> result 0x00000000 (+0); out_valid after E0+4.
- a=0x7F800000, b=0x7F800000, op=1 -> result 0x7FC00000; out_valid after E0+1.
- a=0x3F800000, b=0x33C00000, op=0 (count=24):
  - Without the macro -> 0x3F800000.
  - With FP_ROUND_NEAREST_EN -> 0x3F800001.
  - out_valid after E0+28 in both builds.
- out_ready held low for 5 cycles in DONE -> result and out_valid stable, in_ready=0. Then reset driven low during a subsequent ALIGN -> out_valid=0, result=0; in_ready=1 after release; the next operation completes correctly.

Source files
------------

// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq: multi-cycle IEEE-754 single-precision adder/subtractor.
// Computes a + b (op=0) or a - b (op=1). Alignment and left normalization
// advance one bit per cycle; denormal inputs are flushed to zero.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in_valid   a, b, op valid          in_ready   high only in IDLE
//   a, b       single-precision operands
//   op         0 = add, 1 = subtract
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts result
//   result     single-precision result
//   busy       high in every state except IDLE
//
// Build option: define FP_ROUND_NEAREST_EN for round-to-nearest-even in PACK;
// otherwise results are truncated (round toward zero). Latency is the same.
module fp_addsub_seq #(
  parameter int MAX_ALIGN_SHIFT = 27
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        busy
);
  localparam int CW = $clog2(MAX_ALIGN_SHIFT + 1);

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_PACK, S_DONE} state_t;

  // Mantissa layout (28 bits): [27] carry, [26:3] 24-bit mantissa with
  // hidden bit at [26], [2] guard, [1] round, [0] sticky.
  state_t          state_q, state_d;
  logic [27:0]     mx_q, mx_d;     // larger-exponent operand, later the sum
  logic [27:0]     my_q, my_d;     // smaller-exponent operand, gets aligned
  logic            sx_q, sx_d;
  logic            sy_q, sy_d;
  logic            sign_q, sign_d;
  logic [9:0]      exp_q, exp_d;   // wide so overflow past 254 is visible
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            spec_q, spec_d;
  logic [31:0]     spec_val_q, spec_val_d;
  logic [31:0]     result_q, result_d;
  logic            out_valid_q, out_valid_d;

  // Operand unpacking at acceptance
  logic [7:0]  ea, eb, diff;
  logic        sa, sb, a_ge;
  logic        nan_a, nan_b, inf_a, inf_b;
  logic [27:0] ma, mb;
  logic [CW-1:0] cnt_load;

  assign sa    = a[31];
  assign sb    = b[31] ^ op;
  assign ea    = a[30:23];
  assign eb    = b[30:23];
  assign nan_a = (ea == 8'hFF) && (a[22:0] != 23'd0);
  assign nan_b = (eb == 8'hFF) && (b[22:0] != 23'd0);
  assign inf_a = (ea == 8'hFF) && (a[22:0] == 23'd0);
  assign inf_b = (eb == 8'hFF) && (b[22:0] == 23'd0);
  assign ma    = (ea != 8'd0) ? {2'b01, a[22:0], 3'b000} : 28'd0;
  assign mb    = (eb != 8'd0) ? {2'b01, b[22:0], 3'b000} : 28'd0;
  assign a_ge  = (ea >= eb);
  assign diff  = a_ge ? (ea - eb) : (eb - ea);
  assign cnt_load = (int'(diff) > MAX_ALIGN_SHIFT) ? CW'(MAX_ALIGN_SHIFT) : CW'(diff);

  // Rounding and packing of the normalized sum
  logic [23:0] pk_mant;
  logic [9:0]  pk_exp;
  logic [31:0] pk_res;
`ifdef FP_ROUND_NEAREST_EN
  logic [24:0] pk_inc;
`endif

  always_comb begin
    pk_mant = mx_q[26:3];
    pk_exp  = exp_q;
`ifdef FP_ROUND_NEAREST_EN
    pk_inc  = {1'b0, mx_q[26:3]} + 25'd1;
    if (mx_q[2] && (mx_q[1] || mx_q[0] || mx_q[3])) begin
      if (pk_inc[24]) begin
        pk_mant = 24'h800000;
        pk_exp  = exp_q + 10'd1;
      end else begin
        pk_mant = pk_inc[23:0];
      end
    end
`endif
    if (spec_q)                 pk_res = spec_val_q;
    else if (pk_mant == 24'd0)  pk_res = 32'h0000_0000;
    else if (pk_exp >= 10'd255) pk_res = {sign_q, 8'hFF, 23'd0};
    else if (!pk_mant[23])      pk_res = 32'h0000_0000;  // underflow flushes
    else                        pk_res = {sign_q, pk_exp[7:0], pk_mant[22:0]};
  end

  always_comb begin
    state_d     = state_q;
    mx_d        = mx_q;
    my_d        = my_q;
    sx_d        = sx_q;
    sy_d        = sy_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    cnt_d       = cnt_q;
    spec_d      = spec_q;
    spec_val_d  = spec_val_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (nan_a || nan_b || (inf_a && inf_b && (sa != sb))) begin
            spec_d = 1'b1; spec_val_d = 32'h7FC0_0000; state_d = S_PACK;
          end else if (inf_a) begin
            spec_d = 1'b1; spec_val_d = {sa, 8'hFF, 23'd0}; state_d = S_PACK;
          end else if (inf_b) begin
            spec_d = 1'b1; spec_val_d = {sb, 8'hFF, 23'd0}; state_d = S_PACK;
          end else if ((ea == 8'd0) && (eb == 8'd0)) begin
            spec_d = 1'b1; spec_val_d = 32'h0000_0000; state_d = S_PACK;
          end else begin
            // Keep the larger-exponent operand in mx so only my is shifted.
            spec_d  = 1'b0;
            mx_d    = a_ge ? ma : mb;
            my_d    = a_ge ? mb : ma;
            sx_d    = a_ge ? sa : sb;
            sy_d    = a_ge ? sb : sa;
            exp_d   = {2'b00, a_ge ? ea : eb};
            cnt_d   = cnt_load;
            state_d = S_ALIGN;
          end
        end
      end
      S_ALIGN: begin
        if (cnt_q != '0) begin
          my_d  = {1'b0, my_q[27:2], my_q[1] | my_q[0]};
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        if (sx_q == sy_q) begin
          mx_d = mx_q + my_q; sign_d = sx_q;
        end else if (mx_q > my_q) begin
          mx_d = mx_q - my_q; sign_d = sx_q;
        end else if (my_q > mx_q) begin
          mx_d = my_q - mx_q; sign_d = sy_q;
        end else begin
          mx_d = 28'd0; sign_d = 1'b0;
        end
        state_d = S_NORM;
      end
      S_NORM: begin
        if (mx_q[27]) begin
          mx_d    = {1'b0, mx_q[27:2], mx_q[1] | mx_q[0]};
          exp_d   = exp_q + 10'd1;
          state_d = S_PACK;
        end else if ((mx_q == 28'd0) || mx_q[26] || (exp_q <= 10'd1)) begin
          state_d = S_PACK;
        end else begin
          mx_d  = {mx_q[26:0], 1'b0};
          exp_d = exp_q - 10'd1;
        end
      end
      S_PACK: begin
        result_d    = pk_res;
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      mx_q        <= '0;
      my_q        <= '0;
      sx_q        <= 1'b0;
      sy_q        <= 1'b0;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      cnt_q       <= '0;
      spec_q      <= 1'b0;
      spec_val_q  <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mx_q        <= mx_d;
      my_q        <= my_d;
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      cnt_q       <= cnt_d;
      spec_q      <= spec_d;
      spec_val_q  <= spec_val_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule

// File: tb/tb_fp_addsub_seq.sv
module tb_fp_addsub_seq;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, op, out_valid, out_ready, busy;
  logic [31:0] a, b, result;

  int checks = 0;
  int errors = 0;

  fp_addsub_seq dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: exact-integer alignment with sticky, add, normalize, pack.
  function automatic void model(input logic [31:0] fa, input logic [31:0] fb,
                                input logic fop, output logic [31:0] r, output int lat);
    logic sa, sb, sx, sy, sr;
    int ea, eb, ex, ey, e, c, s;
    longint mx, my, m, mant, mask;
    logic [7:0] e8;
    sa = fa[31]; sb = fb[31] ^ fop;
    ea = int'(fa[30:23]); eb = int'(fb[30:23]);
    lat = 1;
    r = 32'h0;
    if ((ea == 255 && fa[22:0] != 0) || (eb == 255 && fb[22:0] != 0) ||
        (ea == 255 && eb == 255 && sa != sb)) r = 32'h7FC00000;
    else if (ea == 255) r = {sa, 8'hFF, 23'd0};
    else if (eb == 255) r = {sb, 8'hFF, 23'd0};
    else if (ea == 0 && eb == 0) r = 32'h0;
    else begin
      if (ea >= eb) begin
        ex = ea; ey = eb; sx = sa; sy = sb;
        mx = (ea != 0) ? (longint'({1'b1, fa[22:0]}) << 3) : 0;
        my = (eb != 0) ? (longint'({1'b1, fb[22:0]}) << 3) : 0;
      end else begin
        ex = eb; ey = ea; sx = sb; sy = sa;
        mx = (eb != 0) ? (longint'({1'b1, fb[22:0]}) << 3) : 0;
        my = (ea != 0) ? (longint'({1'b1, fa[22:0]}) << 3) : 0;
      end
      c = (ex - ey > 27) ? 27 : ex - ey;
      mask = (longint'(1) << c) - 1;
      my = (my >> c) | (((my & mask) != 0) ? 1 : 0);
      e = ex;
      if (sx == sy) begin m = mx + my; sr = sx; end
      else if (mx > my) begin m = mx - my; sr = sx; end
      else if (my > mx) begin m = my - mx; sr = sy; end
      else begin m = 0; sr = 1'b0; end
      s = 0;
      if (m >= (longint'(1) << 27)) begin m = (m >> 1) | (m & 1); e++; end
      else if (m != 0) begin
        while (m < (longint'(1) << 26) && e > 1) begin m = m * 2; e--; s++; end
      end
      mant = m >> 3;
`ifdef FP_ROUND_NEAREST_EN
      if (((m >> 2) & 1) == 1 && ((m & 3) != 0 || (mant & 1) == 1)) begin
        mant = mant + 1;
        if (mant == (longint'(1) << 24)) begin mant = longint'(1) << 23; e++; end
      end
`endif
      e8 = e[7:0];
      if (mant == 0) r = 32'h0;
      else if (e >= 255) r = {sr, 8'hFF, 23'd0};
      else if (mant < (longint'(1) << 23)) r = 32'h0;
      else r = {sr, e8, mant[22:0]};
      lat = 4 + c + s;
    end
  endfunction

  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic top,
                       input logic [31:0] exp_res, input int exp_lat, input int hold);
    int lat;
    logic [31:0] held;
    @(negedge clk);
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    a = ta; b = tb_v; op = top; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    chk("latency", lat, exp_lat);
    chk("result", result, exp_res);
    chk("busy_done", {31'd0, busy}, 32'd1);
    held = result;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_result", result, held);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    chk("valid_drop", {31'd0, out_valid}, 32'd0);
    chk("in_ready_back", {31'd0, in_ready}, 32'd1);
    $display("op a=%h b=%h op=%0d result=%h expected=%h latency=%0d expected=%0d",
             ta, tb_v, top, result, exp_res, lat, exp_lat);
  endtask

  function automatic logic [31:0] rand_fp();
    int sel;
    logic [7:0] e;
    sel = int'($urandom_range(0, 15));
    e = 8'($urandom_range(118, 136));
    if (sel == 0) return {1'($urandom), 31'd0};
    if (sel == 1) return {1'($urandom), 8'hFF, 23'd0};
    if (sel == 2) return {1'b0, 8'hFF, 23'($urandom_range(1, 8388607))};
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  logic [31:0] ra, rb, rr;
  logic        rop;
  int          rl;

  initial begin
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1 chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    do_op(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4, 0);
    do_op(32'h40000000, 32'h3F000000, 1'b1, 32'h3FC00000, 7, 0);
    do_op(32'h40400000, 32'h40400000, 1'b1, 32'h00000000, 4, 0);
    do_op(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1, 0);
`ifdef FP_ROUND_NEAREST_EN
    do_op(32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 28, 0);
`else
    do_op(32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800000, 28, 0);
`endif
    do_op(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 5, 5);
    do_op(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 1, 0);
    do_op(32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 1, 0);
    do_op(32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 1, 0);
    do_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4, 0);

    // Abort an operation in flight during ALIGN
    @(negedge clk);
    a = 32'h3F800000; b = 32'h33C00000; op = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    #1;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    @(negedge clk) reset = 1'b1;
    #1 chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    $display("abort during ALIGN out_valid=%0d result=%h", out_valid, result);
    do_op(32'h40000000, 32'h3F000000, 1'b1, 32'h3FC00000, 7, 1);

    for (int n = 0; n < 60; n++) begin
      ra = rand_fp();
      rb = ($urandom_range(0, 7) == 0) ? ra : rand_fp();
      rop = 1'($urandom);
      model(ra, rb, rop, rr, rl);
      do_op(ra, rb, rop, rr, rl, int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
